serial_priority_encoder_16x4: RTL and testbench
===============================================

Name: serial_priority_encoder_16x4

Overview:
- Sequential 16-to-4 encoder; the inverse of the team's 4x16 decoder path.
- Captures a 16-bit request vector and emits the 4-bit index of every set bit, one code per handshake, in priority order.
- Carries a "none" flag for an all-zero vector, as in a textbook priority encoder's V output.
- Sits between request-line producers and downstream logic that consumes binary indices, e.g. to drive decoder enables.

Parameters:
- N_LINES, 16, number of request lines; fixed at 16 for this revision.
- CODE_W, 4, code width; must equal log2(N_LINES).
- HIGH_FIRST, 1, 1 = highest set index emitted first; 0 = lowest set index first.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-high reset.
- Req  input  16  request vector; sampled only on input handshake.
- Req_Valid  input  1  Req is valid.
- Req_Ready  output  1  block accepts a new vector.
- Code  output  4  index of the current set bit.
- Code_Valid  output  1  Code/Last/None are valid.
- Code_Ready  input  1  consumer accepts the current code.
- Last  output  1  current code is the final one for this vector.
- None  output  1  captured vector was all-zero; Code=0 on that beat.
- Remaining  output  5  set bits not yet accepted, including the current beat.

Behaviour:
- Rst is synchronous and active-high. At the first rising Clk edge with Rst=1, all registers clear:
  - state=IDLE, pending=0.
  - Code=0, Code_Valid=0, Last=0, None=0, Remaining=0.
- Req_Ready = (state==IDLE) && !Rst; this is the only combinational output.
- Two states:
  - IDLE: Req_Ready=1, Code_Valid=0.
  - SEND: Req_Ready=0, Code_Valid=1.
- Input handshake = Req_Valid && Req_Ready at a rising edge. Req is registered into pending and state moves to SEND.
  - Code_Valid rises the cycle after the handshake (1-cycle latency).
- Non-zero Req:
  - Code = priority index of pending (HIGH_FIRST selects direction).
  - Remaining = popcount(Req), range 1..16.
  - Last = (Remaining==1), None=0.
- Zero Req: one beat with Code=0, None=1, Last=1, Remaining=0.
- Output handshake = Code_Valid && Code_Ready at a rising edge.
  - If Last=0: clear the current bit from pending, decrement Remaining, and present the next index in the very next cycle. No bubble; one code per cycle at full throughput.
  - If Last=1: clear pending, Code_Valid=0, None=0, Last=0, Remaining=0, go IDLE. Req_Ready is 1 in the following cycle.
  - No back-to-back vectors: at least one IDLE cycle between the final code and the next Code_Valid.
- Stall: while Code_Valid=1 and Code_Ready=0, Code, Last, None and Remaining hold stable.
- Req and Req_Valid are ignored in SEND; changing Req mid-sequence has no effect.
- Rst asserted mid-sequence: the in-flight vector is discarded at that edge, and outputs take their reset values. No partial beat completes, even if Code_Ready=1 on the same edge.
- Remaining is 5 bits so that 16 (all-ones vector) is representable.

Test Plan:
- Reset: hold Rst 2 cycles with Req_Valid=1, Req=16'hFFFF -> Code_Valid=0, Code=0, Remaining=0, Req_Ready=0 during Rst and 1 the cycle after release.
- Multi-bit, HIGH_FIRST=1: Req=16'h8421, Code_Ready=1 constant.
  - Codes 15,10,5,0 appear on 4 consecutive cycles starting 1 cycle after the handshake.
  - Remaining 4,3,2,1; Last=1 only on code 0; Req_Ready returns 1 the cycle after.
- Backpressure: Req=16'h0030, Code_Ready low for 3 cycles then high.
  - Code=5 held stable with Remaining=2, Last=0 for 4 cycles.
  - Then Code=4, Last=1; then Code_Valid=0.
- Zero vector: Req=16'h0000 -> single beat Code=0, None=1, Last=1, Remaining=0; next cycle Code_Valid=0.
- All-ones with HIGH_FIRST=0: Req=16'hFFFF -> codes 0..15 in ascending order over 16 cycles, Remaining 16 down to 1, Last only on 15.
- Mid-sequence reset: Req=16'h00FF, Rst asserted after 3 accepted codes with Code_Ready=1 -> no further codes. Then a new Req=16'h0100 yields a single Code=8 with Last=1.

Source files
------------

// File: rtl/serial_priority_encoder_16x4.sv
// Sequential 16-to-4 priority encoder: captures a request vector and emits the index of every
// set bit, one code per output handshake, in priority order, with a "none" beat for all-zero.
module serial_priority_encoder_16x4 #(
  parameter int unsigned N_LINES    = 16,
  parameter int unsigned CODE_W     = 4,
  parameter bit          HIGH_FIRST = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [N_LINES-1:0] Req,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  output logic [CODE_W-1:0] Code,
  output logic              Code_Valid,
  input  logic              Code_Ready,
  output logic              Last,
  output logic              None,
  output logic [CODE_W:0]   Remaining
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSend = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [N_LINES-1:0] pending_q, pending_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic               last_q, last_d;
  logic               none_q, none_d;
  logic [CODE_W:0]    remaining_q, remaining_d;
  logic [N_LINES-1:0] cleared;
  logic [CODE_W:0]    req_count;

  // The later assignment in the scan wins, so scan direction selects the priority.
  function automatic logic [CODE_W-1:0] prio_idx(input logic [N_LINES-1:0] vec);
    logic [CODE_W-1:0] idx;
    idx = '0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < N_LINES; i++) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end else begin
      for (int i = N_LINES - 1; i >= 0; i--) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [CODE_W:0] pop_count(input logic [N_LINES-1:0] vec);
    logic [CODE_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_LINES; i++) begin
      cnt = cnt + (CODE_W + 1)'(vec[i]);
    end
    return cnt;
  endfunction

  assign req_count = pop_count(Req);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    code_d      = code_q;
    last_d      = last_q;
    none_d      = none_q;
    remaining_d = remaining_q;
    cleared     = pending_q & ~(N_LINES'(1) << code_q);

    case (state_q)
      StIdle: begin
        if (Req_Valid) begin
          state_d   = StSend;
          pending_d = Req;
          if (Req == '0) begin
            code_d      = '0;
            none_d      = 1'b1;
            last_d      = 1'b1;
            remaining_d = '0;
          end else begin
            code_d      = prio_idx(Req);
            none_d      = 1'b0;
            last_d      = (req_count == (CODE_W + 1)'(1));
            remaining_d = req_count;
          end
        end
      end
      default: begin
        if (Code_Ready) begin
          if (last_q) begin
            state_d     = StIdle;
            pending_d   = '0;
            code_d      = '0;
            last_d      = 1'b0;
            none_d      = 1'b0;
            remaining_d = '0;
          end else begin
            // Next index is derived from the already-cleared vector so there is no bubble.
            pending_d   = cleared;
            code_d      = prio_idx(cleared);
            remaining_d = remaining_q - (CODE_W + 1)'(1);
            last_d      = (remaining_q == (CODE_W + 1)'(2));
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      code_q      <= '0;
      last_q      <= 1'b0;
      none_q      <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      code_q      <= code_d;
      last_q      <= last_d;
      none_q      <= none_d;
      remaining_q <= remaining_d;
    end
  end

  assign Req_Ready  = (state_q == StIdle) && !Rst;
  assign Code_Valid = (state_q == StSend);
  assign Code       = code_q;
  assign Last       = last_q;
  assign None       = none_q;
  assign Remaining  = remaining_q;

endmodule

// File: tb/tb_serial_priority_encoder_16x4.sv
// Bench for serial_priority_encoder_16x4: one high-first and one low-first instance share the
// same stimulus; every beat is compared against a list of set indices built from the vector.
module tb_serial_priority_encoder_16x4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        req_valid;
  logic        code_ready;

  logic        req_ready_h, code_valid_h, last_h, none_h;
  logic [3:0]  code_h;
  logic [4:0]  rem_h;
  logic        req_ready_l, code_valid_l, last_l, none_l;
  logic [3:0]  code_l;
  logic [4:0]  rem_l;

  int n_checks = 0;
  int n_fail   = 0;
  int first_hi, first_lo, beats_seen;

  always #5 clk = ~clk;

  serial_priority_encoder_16x4 #(.N_LINES(16), .CODE_W(4), .HIGH_FIRST(1'b1)) u_hi (
    .Clk(clk), .Rst(rst), .Req(req), .Req_Valid(req_valid), .Req_Ready(req_ready_h),
    .Code(code_h), .Code_Valid(code_valid_h), .Code_Ready(code_ready), .Last(last_h),
    .None(none_h), .Remaining(rem_h)
  );

  serial_priority_encoder_16x4 #(.N_LINES(16), .CODE_W(4), .HIGH_FIRST(1'b0)) u_lo (
    .Clk(clk), .Rst(rst), .Req(req), .Req_Valid(req_valid), .Req_Ready(req_ready_l),
    .Code(code_l), .Code_Valid(code_valid_l), .Code_Ready(code_ready), .Last(last_l),
    .None(none_l), .Remaining(rem_l)
  );

  typedef struct {
    logic [15:0] req;
    int          n_beats;
    int          first_hi;
    int          first_lo;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one vector through both instances and checks every beat against the index list.
  task automatic run_vec(input logic [15:0] v, input bit rnd);
    int asc[$];
    int n, beats, k, guard;
    for (int i = 0; i < 16; i++) if (v[i]) asc.push_back(i);
    n     = asc.size();
    beats = (n == 0) ? 1 : n;
    chk("idle_valid", int'(code_valid_h), 0);
    chk("idle_ready_h", int'(req_ready_h), 1);
    chk("idle_ready_l", int'(req_ready_l), 1);
    req = v;
    req_valid = 1'b1;
    code_ready = 1'b0;
    step();
    req_valid = 1'b0;
    k = 0;
    guard = 0;
    while (k < beats) begin
      code_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) begin
        req = 16'($urandom);
        req_valid = 1'($urandom_range(0, 1));
      end
      chk("beat_valid_h", int'(code_valid_h), 1);
      chk("beat_valid_l", int'(code_valid_l), 1);
      chk("beat_ready", int'(req_ready_h), 0);
      chk("code_h", int'(code_h), (n == 0) ? 0 : asc[n - 1 - k]);
      chk("code_l", int'(code_l), (n == 0) ? 0 : asc[k]);
      chk("rem_h", int'(rem_h), n - k);
      chk("rem_l", int'(rem_l), n - k);
      chk("last_h", int'(last_h), int'(k == beats - 1));
      chk("last_l", int'(last_l), int'(k == beats - 1));
      chk("none_h", int'(none_h), int'(n == 0));
      chk("none_l", int'(none_l), int'(n == 0));
      if (guard == 0) begin
        first_hi = int'(code_h);
        first_lo = int'(code_l);
      end
      step();
      if (code_ready) k++;
      guard++;
      if (guard > 200) begin
        chk("beat_timeout", 0, 1);
        break;
      end
    end
    beats_seen = k;
    req_valid = 1'b0;
    code_ready = 1'b0;
    chk("end_valid_h", int'(code_valid_h), 0);
    chk("end_valid_l", int'(code_valid_l), 0);
    chk("end_ready", int'(req_ready_h), 1);
  endtask

  initial begin
    tbl[0] = '{req: 16'h8421, n_beats: 4,  first_hi: 15, first_lo: 0};
    tbl[1] = '{req: 16'hFFFF, n_beats: 16, first_hi: 15, first_lo: 0};
    tbl[2] = '{req: 16'h0000, n_beats: 1,  first_hi: 0,  first_lo: 0};
    tbl[3] = '{req: 16'h0001, n_beats: 1,  first_hi: 0,  first_lo: 0};
    tbl[4] = '{req: 16'h8000, n_beats: 1,  first_hi: 15, first_lo: 15};
    tbl[5] = '{req: 16'h0030, n_beats: 2,  first_hi: 5,  first_lo: 4};

    // Reset with a valid request pending: reset must win.
    rst = 1'b1;
    req_valid = 1'b1;
    req = 16'hFFFF;
    code_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_valid", int'(code_valid_h), 0);
      chk("rst_code", int'(code_h), 0);
      chk("rst_rem", int'(rem_h), 0);
      chk("rst_ready", int'(req_ready_h), 0);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("post_rst_ready", int'(req_ready_h), 1);
    step();

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i].req, 1'b0);
      chk("tbl_first_hi", first_hi, tbl[i].first_hi);
      chk("tbl_first_lo", first_lo, tbl[i].first_lo);
      chk("tbl_beats", beats_seen, tbl[i].n_beats);
      step();
    end

    // Backpressure: code held for four cycles before being accepted.
    req = 16'h0030;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      code_ready = (c == 3);
      chk("bp_valid", int'(code_valid_h), 1);
      chk("bp_code", int'(code_h), 5);
      chk("bp_rem", int'(rem_h), 2);
      chk("bp_last", int'(last_h), 0);
      step();
    end
    chk("bp_code2", int'(code_h), 4);
    chk("bp_last2", int'(last_h), 1);
    chk("bp_rem2", int'(rem_h), 1);
    code_ready = 1'b1;
    step();
    chk("bp_done", int'(code_valid_h), 0);
    code_ready = 1'b0;
    step();

    // Mid-sequence reset after three accepted codes.
    req = 16'h00FF;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    code_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();
    chk("mid_pre_code_h", int'(code_h), 4);
    chk("mid_pre_code_l", int'(code_l), 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_valid", int'(code_valid_h), 0);
    chk("mid_rem", int'(rem_h), 0);
    chk("mid_code", int'(code_h), 0);
    chk("mid_ready", int'(req_ready_h), 1);
    code_ready = 1'b0;
    step();
    chk("mid_still_idle", int'(code_valid_h), 0);
    run_vec(16'h0100, 1'b0);
    chk("mid_new_code_h", first_hi, 8);
    chk("mid_new_code_l", first_lo, 8);
    chk("mid_new_beats", beats_seen, 1);
    step();

    // Random vectors with random backpressure and junk on the request side.
    for (int r = 0; r < 40; r++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if (r % 3 == 1) v = v & 16'($urandom) & 16'($urandom);
      if (r % 10 == 7) v = 16'h0000;
      run_vec(v, 1'b1);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
